// File: rtl/accel_mem_port_arbiter.sv
// Shares RAM port A between the CPU bus slave and the accelerator FSM.
// Round-robin req/gnt arbitration with a bounded burst length; read data
// is routed back to whichever requester issued the read one cycle later.
module accel_mem_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cpu_req,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic                    cpu_we,
    input  logic [DATA_WIDTH/8-1:0] cpu_be,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    output logic                    cpu_gnt,
    output logic                    cpu_rvalid,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,

    input  logic                    acc_req,
    input  logic [ADDR_WIDTH-1:0]   acc_addr,
    input  logic                    acc_we,
    input  logic [DATA_WIDTH/8-1:0] acc_be,
    input  logic [DATA_WIDTH-1:0]   acc_wdata,
    output logic                    acc_gnt,
    output logic                    acc_rvalid,
    output logic [DATA_WIDTH-1:0]   acc_rdata,

    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_ACC = 1'b1;
    localparam logic [3:0] MAX_CNT   = 4'(MAX_BURST);

    logic       last_owner;
    logic [3:0] burst_cnt;
    logic       rd_pend;
    logic       rd_owner;

    logic       any_grant;
    logic       pick_acc;

    // Decide the winner; a zero burst count means the previous cycle was idle,
    // so contention goes round-robin away from the last owner.
    always_comb begin
        pick_acc  = 1'b0;
        any_grant = (cpu_req | acc_req) & rst_n;
        if (cpu_req && acc_req) begin
            if (burst_cnt == 4'd0 || burst_cnt >= MAX_CNT) begin
                pick_acc = ~last_owner;
            end else begin
                pick_acc = last_owner;
            end
        end else begin
            pick_acc = acc_req;
        end
        cpu_gnt = any_grant & ~pick_acc;
        acc_gnt = any_grant & pick_acc;
    end

    // Drive the RAM port from the granted requester, or all zeros when idle.
    always_comb begin
        mem_en    = any_grant;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (acc_gnt) begin
            mem_addr  = acc_addr;
            mem_we    = acc_we;
            mem_be    = acc_be;
            mem_wdata = acc_wdata;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_be    = cpu_be;
            mem_wdata = cpu_wdata;
        end
    end

    // Track owner and burst length; an idle cycle clears the burst count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_ACC;
            burst_cnt  <= 4'd0;
        end else if (any_grant) begin
            if (pick_acc == last_owner) begin
                burst_cnt <= (burst_cnt >= MAX_CNT) ? MAX_CNT : burst_cnt + 4'd1;
            end else begin
                last_owner <= pick_acc;
                burst_cnt  <= 4'd1;
            end
        end else begin
            burst_cnt <= 4'd0;
        end
    end

    // Tag each granted read so its data can be steered next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= OWNER_CPU;
        end else begin
            rd_pend  <= any_grant & ~mem_we;
            rd_owner <= pick_acc;
        end
    end

    // Steer returning read data to its owner; the other side sees zeros.
    always_comb begin
        cpu_rvalid = rd_pend & (rd_owner == OWNER_CPU);
        acc_rvalid = rd_pend & (rd_owner == OWNER_ACC);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        acc_rdata  = acc_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_accel_mem_port_arbiter.sv
// Self-checking bench for accel_mem_port_arbiter: directed scenarios plus
// randomized traffic, checked against a behavioural arbitration/RAM model.
module tb_accel_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we, acc_req, acc_we;
    logic [AW-1:0] cpu_addr, acc_addr;
    logic [BW-1:0] cpu_be, acc_be;
    logic [DW-1:0] cpu_wdata, acc_wdata;
    logic          cpu_gnt, cpu_rvalid, acc_gnt, acc_rvalid;
    logic [DW-1:0] cpu_rdata, acc_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

    // Reference model state (from the arbitration rules, not the RTL)
    int            m_last;
    int            m_burst;
    bit            e_pend;
    int            e_owner;
    logic [DW-1:0] e_data;
    int            last_win;

    // Values sampled in the most recent step
    logic          s_cpu_rvalid, s_acc_rvalid;
    logic [DW-1:0] s_cpu_rdata, s_acc_rdata;

    accel_mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .acc_req(acc_req), .acc_addr(acc_addr), .acc_we(acc_we), .acc_be(acc_be),
        .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with one-cycle read latency and byte-enabled writes
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
    endtask

    task automatic set_acc(input logic req, input logic we, input logic [AW-1:0] addr,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        acc_req = req; acc_we = we; acc_addr = addr; acc_be = be; acc_wdata = wd;
    endtask

    task automatic preload(input int addr, input logic [DW-1:0] data);
        ram[addr]     = data;
        ref_mem[addr] = data;
    endtask

    // One clock cycle: check outputs at negedge, advance model at posedge.
    task automatic step(input string tag);
        int            win;
        logic          w_we;
        logic [AW-1:0] w_addr;
        logic [BW-1:0] w_be;
        logic [DW-1:0] w_wd;
        logic [1:0]    e_gnt, e_rv;
        logic [DW-1:0] e_cd, e_ad;
        @(negedge clk);
        if (!rst_n) begin
            m_last = 1; m_burst = 0; e_pend = 0;
        end
        win = -1;
        if (rst_n) begin
            if (cpu_req && acc_req)
                win = (m_burst == 0 || m_burst >= MAXB) ? (1 - m_last) : m_last;
            else if (cpu_req) win = 0;
            else if (acc_req) win = 1;
        end
        w_we = 1'b0; w_addr = '0; w_be = '0; w_wd = '0;
        if (win == 0) begin w_we = cpu_we; w_addr = cpu_addr; w_be = cpu_be; w_wd = cpu_wdata; end
        if (win == 1) begin w_we = acc_we; w_addr = acc_addr; w_be = acc_be; w_wd = acc_wdata; end
        e_gnt = {win == 0, win == 1};
        e_rv  = {e_pend && e_owner == 0, e_pend && e_owner == 1};
        e_cd  = e_rv[1] ? e_data : '0;
        e_ad  = e_rv[0] ? e_data : '0;

        checks++;
        if ({cpu_gnt, acc_gnt} !== e_gnt) begin
            errors++;
            $display("[TB] FAIL %s gnt{cpu,acc}: got %b expected %b", tag, {cpu_gnt, acc_gnt}, e_gnt);
        end
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== {win >= 0, w_we, w_addr, w_be, w_wd}) begin
            errors++;
            $display("[TB] FAIL %s mem_bus: got en=%b we=%b a=%0h be=%h wd=%h expected en=%b we=%b a=%0h be=%h wd=%h",
                     tag, mem_en, mem_we, mem_addr, mem_be, mem_wdata, win >= 0, w_we, w_addr, w_be, w_wd);
        end
        checks++;
        if ({cpu_rvalid, acc_rvalid} !== e_rv) begin
            errors++;
            $display("[TB] FAIL %s rvalid{cpu,acc}: got %b expected %b", tag, {cpu_rvalid, acc_rvalid}, e_rv);
        end
        checks++;
        if (cpu_rdata !== e_cd) begin
            errors++;
            $display("[TB] FAIL %s cpu_rdata: got %h expected %h", tag, cpu_rdata, e_cd);
        end
        checks++;
        if (acc_rdata !== e_ad) begin
            errors++;
            $display("[TB] FAIL %s acc_rdata: got %h expected %h", tag, acc_rdata, e_ad);
        end
        s_cpu_rvalid = cpu_rvalid; s_acc_rvalid = acc_rvalid;
        s_cpu_rdata  = cpu_rdata;  s_acc_rdata  = acc_rdata;

        @(posedge clk);
        e_pend = 0;
        if (win >= 0) begin
            if (w_we) begin
                for (int b = 0; b < BW; b++)
                    if (w_be[b]) ref_mem[w_addr][b*8 +: 8] = w_wd[b*8 +: 8];
            end else begin
                e_pend = 1; e_owner = win; e_data = ref_mem[w_addr];
            end
            if (win == m_last) begin
                m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
            end else begin
                m_last = win; m_burst = 1;
            end
        end else if (rst_n) begin
            m_burst = 0;
        end
        last_win = win;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_cpu(1, 0, 10'd1, 4'hF, 32'h0);
        set_acc(1, 1, 10'd2, 4'hF, 32'h5);
        step("reset_a");
        step("reset_b");
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step("reset_idle");
    endtask

    task automatic test_cpu_write_read();
        set_cpu(1, 1, 10'd5, 4'hF, 32'hDEADBEEF);
        step("cpu_wr");
        checks++;
        if (last_win !== 0) begin errors++; $display("[TB] FAIL cpu_wr_gnt: got %0d expected 0", last_win); end
        set_cpu(1, 0, 10'd5, 4'h0, 32'h0);
        step("cpu_rd");
        set_cpu(0, 0, 0, 0, 0);
        step("cpu_rd_ret");
        checks++;
        if (s_cpu_rvalid !== 1'b1 || s_cpu_rdata !== 32'hDEADBEEF || s_acc_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_readback: got v=%b d=%h accv=%b expected v=1 d=deadbeef accv=0",
                     s_cpu_rvalid, s_cpu_rdata, s_acc_rvalid);
        end
    endtask

    task automatic test_burst_rr();
        int seq_err = 0;
        rst_n = 1'b0;
        set_cpu(1, 0, 10'd1, 4'h0, 0);
        set_acc(1, 0, 10'd2, 4'h0, 0);
        step("burst_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step("burst");
            if (last_win !== (i / 4) % 2) seq_err++;
        end
        checks++;
        if (seq_err != 0) begin
            errors++;
            $display("[TB] FAIL burst_sequence: got %0d wrong grants expected 0", seq_err);
        end
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        step("burst_drain");
    endtask

    task automatic test_concurrent_reads();
        int bad = 0;
        int seen = 0;
        preload(3, 32'h33);
        preload(7, 32'h77);
        set_cpu(1, 0, 10'd7, 4'h0, 0);
        set_acc(1, 0, 10'd3, 4'h0, 0);
        for (int i = 0; i < 12; i++) begin
            step("conc_rd");
            if (s_cpu_rvalid) begin seen++; if (s_cpu_rdata !== 32'h77) bad++; end
            if (s_acc_rvalid) begin seen++; if (s_acc_rdata !== 32'h33) bad++; end
        end
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        step("conc_drain");
        if (s_cpu_rvalid) begin seen++; if (s_cpu_rdata !== 32'h77) bad++; end
        if (s_acc_rvalid) begin seen++; if (s_acc_rdata !== 32'h33) bad++; end
        checks++;
        if (bad != 0 || seen != 12) begin
            errors++;
            $display("[TB] FAIL conc_routing: got bad=%0d returns=%0d expected bad=0 returns=12", bad, seen);
        end
    endtask

    task automatic test_partial_write();
        preload(9, 32'h11223344);
        set_cpu(1, 1, 10'd9, 4'b0010, 32'h0000AB00);
        step("pw_wr");
        set_cpu(1, 0, 10'd9, 4'h0, 0);
        step("pw_rd");
        set_cpu(0, 0, 0, 0, 0);
        step("pw_ret");
        checks++;
        if (s_cpu_rvalid !== 1'b1 || s_cpu_rdata !== 32'h1122AB44) begin
            errors++;
            $display("[TB] FAIL partial_write: got v=%b d=%h expected v=1 d=1122ab44", s_cpu_rvalid, s_cpu_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        set_cpu(0, 0, 0, 0, 0);
        set_acc(1, 0, 10'd3, 4'h0, 0);
        step("mid_grant");
        rst_n = 1'b0;
        set_cpu(1, 0, 10'd7, 4'h0, 0);
        step("mid_rst_a");
        checks++;
        if (s_acc_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_rvalid: got %b expected 0", s_acc_rvalid);
        end
        step("mid_rst_b");
        rst_n = 1'b1;
        step("mid_release");
        checks++;
        if (last_win !== 0) begin
            errors++;
            $display("[TB] FAIL mid_first_contention: got %0d expected 0", last_win);
        end
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        step("mid_drain");
    endtask

    task automatic test_idle_clears_burst();
        int acc_at = -1;
        set_cpu(0, 0, 0, 0, 0);
        set_acc(1, 0, 10'd4, 4'h0, 0);
        for (int i = 0; i < 3; i++) step("idle_acc");
        set_acc(0, 0, 0, 0, 0);
        step("idle_gap");
        set_cpu(1, 0, 10'd6, 4'h0, 0);
        set_acc(1, 0, 10'd4, 4'h0, 0);
        step("idle_first");
        checks++;
        if (last_win !== 0) begin
            errors++;
            $display("[TB] FAIL idle_first_grant: got %0d expected 0", last_win);
        end
        for (int i = 0; i < 6; i++) begin
            step("idle_then");
            if (last_win == 1 && acc_at < 0) acc_at = i;
        end
        checks++;
        if (acc_at != 3) begin
            errors++;
            $display("[TB] FAIL idle_acc_turn: got step %0d expected 3", acc_at);
        end
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        step("idle_drain");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!cpu_req || last_win == 0) begin
                if ($urandom_range(0, 3) != 0)
                    set_cpu(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 4'($urandom), $urandom);
                else
                    set_cpu(0, 0, 0, 0, 0);
            end
            if (!acc_req || last_win == 1) begin
                if ($urandom_range(0, 3) != 0)
                    set_acc(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 4'($urandom), $urandom);
                else
                    set_acc(0, 0, 0, 0, 0);
            end
            step("random");
        end
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        step("random_drain");
    endtask

    initial begin
        m_last = 1; m_burst = 0; e_pend = 0; e_owner = 0; e_data = '0; last_win = -1;
        for (int a = 0; a < (1 << AW); a++) preload(a, '0);
        rst_n = 1'b0;
        set_cpu(0, 0, 0, 0, 0);
        set_acc(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_cpu_write_read();
        test_burst_rr();
        test_concurrent_reads();
        test_partial_write();
        test_reset_mid_read();
        test_idle_clears_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
